// File: rtl/crc_pkg.sv
// Shared constants and bit-level helpers for the streaming CRC engine.
// Helpers work on a 64-bit register holding the CRC left-aligned, so one function serves every CRC_W.
package crc_pkg;

  localparam logic [31:0] ETH_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] ETH_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] ETH_XOROUT  = 32'hFFFF_FFFF;
  localparam logic [31:0] ETH_RESIDUE = 32'hC704_DD7B;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } crc_state_e;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [63:0] bit_reverse(input logic [63:0] v, input int unsigned w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[i] = v[63-i];
    return r >> (64 - w);
  endfunction

  // One MSB-first byte through the LFSR. crc and poly are both left-aligned in 64 bits.
  function automatic logic [63:0] crc_byte_step(input logic [63:0] crc, input logic [7:0] data,
                                                input logic [63:0] poly);
    logic [63:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[63] ^ data[i];
      c  = c << 1;
      if (fb) c = c ^ poly;
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_stream_if.sv
// Beat input and result output handshakes of crc_stream, bundled as one interface.
interface crc_stream_if #(
  parameter int DW    = 32,
  parameter int CRC_W = 32,
  parameter int LEN_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DW-1:0]     s_data;
  logic [DW/8-1:0]   s_keep;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [CRC_W-1:0]  m_crc;
  logic              m_ok;
  logic [LEN_W-1:0]  m_len;

  modport slave (
    input  s_valid, s_data, s_keep, s_last, m_ready,
    output s_ready, m_valid, m_crc, m_ok, m_len
  );

  modport master (
    output s_valid, s_data, s_keep, s_last, m_ready,
    input  s_ready, m_valid, m_crc, m_ok, m_len
  );
endinterface

// File: rtl/crc_lane_fold.sv
// Combinational fold of all kept byte lanes of one beat into the running CRC, lane 0 first.
module crc_lane_fold
  import crc_pkg::*;
#(
  parameter int               DW    = 32,
  parameter int               CRC_W = 32,
  parameter logic [CRC_W-1:0] POLY  = ETH_POLY,
  parameter bit               REFIN = 1'b1
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [DW-1:0]    data,
  input  logic [DW/8-1:0]  keep,
  output logic [CRC_W-1:0] crc_out
);
  localparam int          LANES   = DW / 8;
  localparam logic [63:0] POLY_AL = 64'(POLY) << (64 - CRC_W);

  logic [63:0] acc;
  logic [7:0]  lane_byte;

  // NOTE: every variable written here gets a value before any branch, so no path can infer a latch.
  always_comb begin
    acc       = 64'(crc_in) << (64 - CRC_W);
    lane_byte = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_byte = data[8*i +: 8];
      if (REFIN) lane_byte = 8'(bit_reverse(64'(lane_byte), 8));
      if (keep[i]) acc = crc_byte_step(acc, lane_byte, POLY_AL);
    end
    crc_out = CRC_W'(acc >> (64 - CRC_W));
  end

endmodule

// File: rtl/crc_stream.sv
// Streaming CRC engine: frame FSM, saturating byte counter, single result buffer and handshakes.
module crc_stream
  import crc_pkg::*;
#(
  parameter int               DW      = 32,
  parameter int               CRC_W   = 32,
  parameter logic [CRC_W-1:0] POLY    = ETH_POLY,
  parameter logic [CRC_W-1:0] INIT    = ETH_INIT,
  parameter logic [CRC_W-1:0] XOROUT  = ETH_XOROUT,
  parameter bit               REFIN   = 1'b1,
  parameter bit               REFOUT  = 1'b1,
  parameter logic [CRC_W-1:0] RESIDUE = ETH_RESIDUE,
  parameter int               LEN_W   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         mode,
  output logic         busy,
  crc_stream_if.slave  bus
);
  localparam int LANES = DW / 8;

  crc_state_e       state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic             m_valid_q, m_valid_d;
  logic [CRC_W-1:0] m_crc_q, m_crc_d;
  logic             m_ok_q, m_ok_d;
  logic [LEN_W-1:0] m_len_q, m_len_d;

  logic             s_ready;
  logic             accept;
  logic             mode_eff;
  logic [CRC_W-1:0] crc_fold;
  logic [CRC_W-1:0] crc_result;
  logic [LEN_W:0]   keep_cnt;
  logic [LEN_W:0]   len_sum;
  logic [LEN_W-1:0] len_next;

  crc_lane_fold #(
    .DW    (DW),
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .REFIN (REFIN)
  ) u_fold (
    .crc_in  (crc_q),
    .data    (bus.s_data),
    .keep    (bus.s_keep),
    .crc_out (crc_fold)
  );

  // A beat may enter in the same cycle the pending result is popped.
  assign s_ready  = !clear && (!m_valid_q || bus.m_ready);
  assign accept   = bus.s_valid && s_ready;
  assign mode_eff = (state_q == ST_IDLE) ? mode : mode_q;

  assign crc_result = (REFOUT ? CRC_W'(bit_reverse(64'(crc_fold), CRC_W)) : crc_fold) ^ XOROUT;

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < LANES; i++) keep_cnt = keep_cnt + (LEN_W + 1)'(bus.s_keep[i]);
    len_sum  = {1'b0, len_q} + keep_cnt;
    len_next = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    mode_d    = mode_q;
    m_valid_d = m_valid_q;
    m_crc_d   = m_crc_q;
    m_ok_d    = m_ok_q;
    m_len_d   = m_len_q;

    if (m_valid_q && bus.m_ready) m_valid_d = 1'b0;

    // clear only drops the frame in flight; a pending result stays for the consumer.
    if (clear) begin
      state_d = ST_IDLE;
      crc_d   = INIT;
      len_d   = '0;
    end else if (accept) begin
      if (bus.s_last) begin
        state_d   = ST_IDLE;
        crc_d     = INIT;
        len_d     = '0;
        m_valid_d = 1'b1;
        m_crc_d   = crc_result;
        m_ok_d    = mode_eff && (crc_fold == RESIDUE);
        m_len_d   = len_next;
      end else begin
        state_d = ST_ACTIVE;
        crc_d   = crc_fold;
        len_d   = len_next;
        mode_d  = mode_eff;
      end
    end
  end

  // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      crc_q     <= INIT;
      len_q     <= '0;
      mode_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_crc_q   <= '0;
      m_ok_q    <= 1'b0;
      m_len_q   <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      m_valid_q <= m_valid_d;
      m_crc_q   <= m_crc_d;
      m_ok_q    <= m_ok_d;
      m_len_q   <= m_len_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_crc   = m_crc_q;
  assign bus.m_ok    = m_ok_q;
  assign bus.m_len   = m_len_q;
  assign busy        = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_crc_stream.sv
// Self-checking bench for crc_stream: 32-bit and 8-bit instances scored against a byte-wide
// reflected CRC-32 reference, with a result queue per instance.
module tb_crc_stream;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [31:0] crc;
    logic [15:0] len;
    logic        ok;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clear32, mode32, busy32;
  logic clear8, mode8, busy8;

  always #5 clk = ~clk;

  crc_stream_if #(.DW(32), .CRC_W(32), .LEN_W(16)) if32 ();
  crc_stream_if #(.DW(8),  .CRC_W(32), .LEN_W(16)) if8 ();

  crc_stream #(.DW(32)) dut32 (
    .clk (clk), .rst_n (rst_n), .clear (clear32), .mode (mode32), .busy (busy32), .bus (if32)
  );
  crc_stream #(.DW(8)) dut8 (
    .clk (clk), .rst_n (rst_n), .clear (clear8), .mode (mode8), .busy (busy8), .bus (if8)
  );

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t q32[$];
  exp_t q8[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Legacy byte-wide generator: reflected CRC-32, LSB-first, poly 0xEDB88320.
  function automatic exp_t legacy_crc32(input byte_q_t b, input bit md);
    exp_t        e;
    logic [31:0] r;
    r = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      r = r ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    e.crc = ~r;
    e.len = 16'(b.size());
    e.ok  = md && (r == 32'hDEBB_20E3);
    return e;
  endfunction

  function automatic byte_q_t str_bytes(input string s);
    byte_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  always @(negedge clk) begin : sb32
    exp_t e;
    if (rst_n && if32.m_valid && if32.m_ready) begin
      check("sb32_pending", q32.size() != 0, 1);
      if (q32.size() != 0) begin
        e = q32.pop_front();
        check("crc32", if32.m_crc, e.crc);
        check("len32", if32.m_len, e.len);
        check("ok32",  if32.m_ok,  e.ok);
      end
    end
  end

  always @(negedge clk) begin : sb8
    exp_t e;
    if (rst_n && if8.m_valid && if8.m_ready) begin
      check("sb8_pending", q8.size() != 0, 1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        check("crc8", if8.m_crc, e.crc);
        check("len8", if8.m_len, e.len);
        check("ok8",  if8.m_ok,  e.ok);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called one step after a rising edge; returns one step after the edge that took the beat.
  task automatic drive_beat(input bit sel8, input logic [31:0] data, input logic [3:0] keep,
                            input bit last, input bit md);
    bit done;
    done = 1'b0;
    if (sel8) begin
      if8.s_valid = 1'b1; if8.s_data = data[7:0]; if8.s_keep = keep[0]; if8.s_last = last;
      mode8 = md;
    end else begin
      if32.s_valid = 1'b1; if32.s_data = data; if32.s_keep = keep; if32.s_last = last;
      mode32 = md;
    end
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      done = sel8 ? if8.s_ready : if32.s_ready;
    end
    check("beat_accept", done, 1);
    sync();
    if (sel8) begin if8.s_valid = 1'b0; if8.s_last = 1'b0; end
    else begin if32.s_valid = 1'b0; if32.s_last = 1'b0; end
  endtask

  task automatic send_frame(input bit sel8, input byte_q_t b, input bit md, input bit empty_last);
    int          bpb, n, nb;
    logic [31:0] data;
    logic [3:0]  keep;
    bpb = sel8 ? 1 : 4;
    n   = b.size();
    nb  = (n + bpb - 1) / bpb;
    if (sel8) q8.push_back(legacy_crc32(b, md));
    else q32.push_back(legacy_crc32(b, md));
    for (int i = 0; i < nb; i++) begin
      data = '0;
      keep = '0;
      for (int k = 0; k < bpb; k++) begin
        if (i * bpb + k < n) begin
          data[8*k +: 8] = b[i*bpb + k];
          keep[k]        = 1'b1;
        end
      end
      drive_beat(sel8, data, keep, (i == nb - 1) && !empty_last, md);
    end
    if (empty_last || nb == 0) drive_beat(sel8, '0, '0, 1'b1, md);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t s9, fr;
    rst_n = 1'b0;
    clear32 = 1'b0; mode32 = 1'b0; clear8 = 1'b0; mode8 = 1'b0;
    if32.s_valid = 1'b0; if32.s_data = '0; if32.s_keep = '0; if32.s_last = 1'b0; if32.m_ready = 1'b1;
    if8.s_valid  = 1'b0; if8.s_data  = '0; if8.s_keep  = '0; if8.s_last  = 1'b0; if8.m_ready  = 1'b1;
    s9 = str_bytes("123456789");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_m_valid", if32.m_valid, 0);
    check("rst_m_crc",   if32.m_crc,   0);
    check("rst_m_ok",    if32.m_ok,    0);
    check("rst_m_len",   if32.m_len,   0);
    check("rst_busy",    busy32,       0);
    check("rst_s_ready", if32.s_ready, 1);

    // Generate mode, check value
    sync();
    send_frame(1'b0, s9, 1'b0, 1'b0);
    @(negedge clk);
    check("gen_latency", if32.m_valid, 1);
    check("gen_crc",     if32.m_crc,   32'hCBF4_3926);
    check("gen_len",     if32.m_len,   9);

    // Check mode: data + FCS, then a corrupted copy
    fr = s9;
    fr.push_back(8'h26); fr.push_back(8'h39); fr.push_back(8'hF4); fr.push_back(8'hCB);
    sync();
    send_frame(1'b0, fr, 1'b1, 1'b0);
    @(negedge clk);
    check("chk_ok_good", if32.m_ok, 1);
    check("chk_len",     if32.m_len, 13);
    fr[4] = fr[4] ^ 8'h10;
    sync();
    send_frame(1'b0, fr, 1'b1, 1'b0);
    @(negedge clk);
    check("chk_ok_bad", if32.m_ok, 0);

    // Backpressure: result held while the next frame waits
    sync();
    if32.m_ready = 1'b0;
    send_frame(1'b0, s9, 1'b0, 1'b0);
    q32.push_back(legacy_crc32(str_bytes("1234"), 1'b0));
    if32.s_valid = 1'b1; if32.s_data = {8'h34, 8'h33, 8'h32, 8'h31};
    if32.s_keep  = 4'hF; if32.s_last = 1'b1; mode32 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_s_ready", if32.s_ready, 0);
      check("bp_m_valid", if32.m_valid, 1);
      check("bp_m_crc",   if32.m_crc,   32'hCBF4_3926);
    end
    sync();
    if32.m_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", if32.s_ready, 1);
    sync();
    if32.s_valid = 1'b0; if32.s_last = 1'b0;
    @(negedge clk);
    check("bp_reload_valid", if32.m_valid, 1);

    // clear mid-frame, with a beat presented during clear
    sync();
    drive_beat(1'b0, {8'h34, 8'h33, 8'h32, 8'h31}, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    check("busy_mid_frame", busy32, 1);
    sync();
    clear32 = 1'b1;
    if32.s_valid = 1'b1; if32.s_data = 32'hDEAD_BEEF; if32.s_keep = 4'hF; if32.s_last = 1'b0;
    @(negedge clk);
    check("clear_s_ready", if32.s_ready, 0);
    sync();
    clear32 = 1'b0; if32.s_valid = 1'b0;
    @(negedge clk);
    check("clear_busy", busy32, 0);
    sync();
    send_frame(1'b0, s9, 1'b0, 1'b0);
    @(negedge clk);
    check("clear_crc", if32.m_crc, 32'hCBF4_3926);
    check("clear_len", if32.m_len, 9);

    // Empty last beat after 8 full bytes
    sync();
    send_frame(1'b0, str_bytes("12345678"), 1'b0, 1'b1);
    @(negedge clk);
    check("keep0_len", if32.m_len, 8);

    // Random frames with partial final beats and random mode
    sync();
    for (int f = 0; f < 4; f++)
      send_frame(1'b0, rand_bytes($urandom_range(1, 23)), 1'($urandom_range(0, 1)), 1'b0);

    // 8-bit instance against the legacy generator
    for (int f = 0; f < 3; f++) send_frame(1'b1, rand_bytes(60), 1'b0, 1'b0);

    // Reset pulsed in the middle of an 8-bit frame
    for (int i = 0; i < 10; i++) drive_beat(1'b1, 32'($urandom_range(0, 255)), 4'h1, 1'b0, 1'b0);
    @(negedge clk);
    check("rst8_busy_before", busy8, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst8_m_valid", if8.m_valid, 0);
    check("rst8_m_crc",   if8.m_crc,   0);
    check("rst8_m_ok",    if8.m_ok,    0);
    check("rst8_m_len",   if8.m_len,   0);
    check("rst8_busy",    busy8,       0);
    check("rst8_s_ready", if8.s_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(1'b1, rand_bytes(60), 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("q32_drained", q32.size(), 0);
    check("q8_drained",  q8.size(),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
